// File: rtl/bus_rr_arbiter_if.sv
// Host-side and device-side signal bundle of the shared bus. The arbiter takes
// the slave view; whatever drives hosts and models devices takes the master view.
interface bus_rr_arbiter_if #(
    parameter int NrHosts      = 2,
    parameter int NrDevices    = 8,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
);
    logic [NrHosts-1:0]                       host_req_i;
    logic [NrHosts-1:0]                       host_gnt_o;
    logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i;
    logic [NrHosts-1:0]                       host_we_i;
    logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i;
    logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i;
    logic [NrHosts-1:0]                       host_rvalid_o;
    logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o;
    logic [NrHosts-1:0]                       host_err_o;

    logic [NrDevices-1:0]                     device_req_o;
    logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o;
    logic [NrDevices-1:0]                     device_we_o;
    logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o;
    logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o;
    logic [NrDevices-1:0]                     device_rvalid_i;
    logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i;
    logic [NrDevices-1:0]                     device_err_i;

    logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base;
    logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        input  device_rvalid_i, device_rdata_i, device_err_i,
        input  cfg_device_addr_base, cfg_device_addr_mask
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
        output device_rvalid_i, device_rdata_i, device_err_i,
        output cfg_device_addr_base, cfg_device_addr_mask
    );
endinterface

// File: rtl/bus_rr_arbiter.sv
// N-host x M-device bus: round-robin arbitration, address decode, and an
// in-order response tracker allowing several transactions in flight.
module bus_rr_arbiter #(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 8,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    bus_rr_arbiter_if.slave  bus
);
    localparam int HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int DevW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int TgtW  = $clog2(NrDevices + 1);
    localparam int PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW  = $clog2(MaxOutstanding + 1);
    localparam logic [TgtW-1:0] TgtDerr = TgtW'(NrDevices);

    logic [HostW-1:0] rr_ptr_q, rr_ptr_d;
    logic [TgtW-1:0]  last_tgt_q, last_tgt_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [HostW-1:0] fifo_host_q [MaxOutstanding];
    logic [HostW-1:0] fifo_host_d [MaxOutstanding];
    logic [TgtW-1:0]  fifo_tgt_q  [MaxOutstanding];
    logic [TgtW-1:0]  fifo_tgt_d  [MaxOutstanding];

    logic                    win_valid;
    logic [HostW-1:0]        win_idx;
    logic [HostW-1:0]        scan;
    logic [AddressWidth-1:0] win_addr;
    logic [TgtW-1:0]         win_tgt;
    logic                    win_derr;
    logic                    gnt;
    logic [HostW-1:0]        head_host;
    logic [TgtW-1:0]         head_tgt;
    logic                    head_valid, head_derr, pop;
    logic [NrDevices-1:0]    expected_rvalid;
    logic                    spurious_rvalid;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int i = 1; i <= NrHosts; i++) begin
            scan = HostW'((int'(rr_ptr_q) + i) % NrHosts);
            if (!win_valid && bus.host_req_i[scan]) begin
                win_valid = 1'b1;
                win_idx   = scan;
            end
        end
    end

    // Descending scan so the lowest hitting device index is the one that sticks.
    always_comb begin
        win_addr = bus.host_addr_i[win_idx];
        win_tgt  = TgtDerr;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((win_addr & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d]) begin
                win_tgt = TgtW'(d);
            end
        end
    end

    // A slot freed by a same-cycle pop is not reused, and a target switch waits
    // for the tracker to drain so responses can never overtake each other.
    assign win_derr = (win_tgt == TgtDerr);
    assign gnt = rst_ni && win_valid && (count_q != CntW'(MaxOutstanding)) &&
                 !((count_q != '0) && (win_tgt != last_tgt_q));

    always_comb begin
        bus.host_gnt_o     = '0;
        bus.device_req_o   = '0;
        bus.device_addr_o  = '0;
        bus.device_we_o    = '0;
        bus.device_be_o    = '0;
        bus.device_wdata_o = '0;
        if (gnt) begin
            bus.host_gnt_o[win_idx] = 1'b1;
            if (!win_derr) begin
                bus.device_req_o[win_tgt[DevW-1:0]]   = 1'b1;
                bus.device_addr_o[win_tgt[DevW-1:0]]  = win_addr;
                bus.device_we_o[win_tgt[DevW-1:0]]    = bus.host_we_i[win_idx];
                bus.device_be_o[win_tgt[DevW-1:0]]    = bus.host_be_i[win_idx];
                bus.device_wdata_o[win_tgt[DevW-1:0]] = bus.host_wdata_i[win_idx];
            end
        end
    end

    assign head_host  = fifo_host_q[rd_ptr_q];
    assign head_tgt   = fifo_tgt_q[rd_ptr_q];
    assign head_valid = rst_ni && (count_q != '0);
    assign head_derr  = (head_tgt == TgtDerr);
    assign pop        = head_valid && (head_derr || bus.device_rvalid_i[head_tgt[DevW-1:0]]);

    always_comb begin
        bus.host_rvalid_o = '0;
        bus.host_rdata_o  = '0;
        bus.host_err_o    = '0;
        if (pop) begin
            bus.host_rvalid_o[head_host] = 1'b1;
            if (head_derr) begin
                bus.host_err_o[head_host] = 1'b1;
            end else begin
                bus.host_rdata_o[head_host] = bus.device_rdata_i[head_tgt[DevW-1:0]];
                bus.host_err_o[head_host]   = bus.device_err_i[head_tgt[DevW-1:0]];
            end
        end
    end

    // Any device response not owed by the head entry is a protocol violation.
    assign expected_rvalid = (head_valid && !head_derr) ?
                             (NrDevices'(1) << head_tgt[DevW-1:0]) : '0;
    assign spurious_rvalid = rst_ni && |(bus.device_rvalid_i & ~expected_rvalid);

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        last_tgt_d = last_tgt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fifo_host_d = fifo_host_q;
        fifo_tgt_d  = fifo_tgt_q;
        if (gnt) begin
            fifo_host_d[wr_ptr_q] = win_idx;
            fifo_tgt_d[wr_ptr_q]  = win_tgt;
            wr_ptr_d   = ptr_inc(wr_ptr_q);
            last_tgt_d = win_tgt;
            rr_ptr_d   = win_idx;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({gnt, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= HostW'(NrHosts - 1);
            last_tgt_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int k = 0; k < MaxOutstanding; k++) begin
                fifo_host_q[k] <= '0;
                fifo_tgt_q[k]  <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            last_tgt_q  <= last_tgt_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_host_q <= fifo_host_d;
            fifo_tgt_q  <= fifo_tgt_d;
        end
    end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: 2 hosts, 8 devices (RAM, GPIO, slow dev),
// response tracker depth 2.
module tb_bus_rr_arbiter;
    localparam int NH = 2;
    localparam int ND = 8;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    localparam logic [AW-1:0] RamA0  = 32'h0010_0004;
    localparam logic [AW-1:0] RamA1  = 32'h0010_0008;
    localparam logic [AW-1:0] SlowA  = 32'h8000_1000;
    localparam logic [AW-1:0] Unmap  = 32'h7000_0000;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bus_rr_arbiter_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW)) bus ();

    bus_rr_arbiter #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host(input int h, input logic req, input logic [AW-1:0] addr);
        bus.host_req_i[h]   = req;
        bus.host_addr_i[h]  = addr;
        bus.host_we_i[h]    = 1'b0;
        bus.host_be_i[h]    = 4'hF;
        bus.host_wdata_i[h] = 32'h0;
    endtask

    task automatic dev(input int d, input logic vld, input logic [DW-1:0] data);
        bus.device_rvalid_i[d] = vld;
        bus.device_rdata_i[d]  = data;
        bus.device_err_i[d]    = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.host_req_i = '0; bus.host_addr_i = '0; bus.host_we_i = '0;
        bus.host_be_i = '0; bus.host_wdata_i = '0;
        bus.device_rvalid_i = '0; bus.device_rdata_i = '0; bus.device_err_i = '0;
        for (int d = 0; d < ND; d++) begin
            bus.cfg_device_addr_base[d] = 32'hFFFF_FFFF;
            bus.cfg_device_addr_mask[d] = 32'h0;
        end
        bus.cfg_device_addr_base[0] = 32'h0010_0000; bus.cfg_device_addr_mask[0] = 32'hFFF0_0000;
        bus.cfg_device_addr_base[1] = 32'h8000_0000; bus.cfg_device_addr_mask[1] = 32'hFFFF_F000;
        bus.cfg_device_addr_base[2] = 32'h8000_1000; bus.cfg_device_addr_mask[2] = 32'hFFFF_F000;

        // Reset with requests and responses pending on the inputs
        rst_n = 1'b0;
        host(0, 1'b1, RamA0); host(1, 1'b1, RamA1);
        bus.device_rvalid_i = '1;
        #2;
        chk("rst_gnt", 64'(bus.host_gnt_o), 64'h0);
        chk("rst_dreq", 64'(bus.device_req_o), 64'h0);
        chk("rst_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        chk("rst_count", 64'(dut.count_q), 64'h0);
        tick(); tick();
        host(0, 1'b0, '0); host(1, 1'b0, '0);
        bus.device_rvalid_i = '0;
        rst_n = 1'b1;
        #1;

        // 1: both hosts hammer RAM, grants alternate, one response per cycle
        host(0, 1'b1, RamA0); host(1, 1'b1, RamA1);
        #1;
        chk("t1_gnt_a", 64'(bus.host_gnt_o), 64'h1);
        chk("t1_dreq_a", 64'(bus.device_req_o), 64'h1);
        chk("t1_daddr_a", 64'(bus.device_addr_o[0]), 64'(RamA0));
        tick();
        dev(0, 1'b1, 32'hAAAA_0000);
        #1;
        chk("t1_gnt_b", 64'(bus.host_gnt_o), 64'h2);
        chk("t1_daddr_b", 64'(bus.device_addr_o[0]), 64'(RamA1));
        chk("t1_rvalid_b", 64'(bus.host_rvalid_o), 64'h1);
        chk("t1_rdata_b", 64'(bus.host_rdata_o[0]), 64'hAAAA_0000);
        tick();
        dev(0, 1'b1, 32'hBBBB_0001);
        #1;
        chk("t1_gnt_c", 64'(bus.host_gnt_o), 64'h1);
        chk("t1_rvalid_c", 64'(bus.host_rvalid_o), 64'h2);
        chk("t1_rdata_c", 64'(bus.host_rdata_o[1]), 64'hBBBB_0001);
        tick();
        host(0, 1'b0, '0); host(1, 1'b0, '0);
        dev(0, 1'b1, 32'hCCCC_0002);
        #1;
        chk("t1_gnt_d", 64'(bus.host_gnt_o), 64'h0);
        chk("t1_rvalid_d", 64'(bus.host_rvalid_o), 64'h1);
        tick();
        dev(0, 1'b0, '0);
        #1;
        chk("t1_count", 64'(dut.count_q), 64'h0);

        // 2: unmapped address completes next cycle with an error
        host(0, 1'b1, Unmap);
        #1;
        chk("t2_gnt", 64'(bus.host_gnt_o), 64'h1);
        chk("t2_dreq", 64'(bus.device_req_o), 64'h0);
        tick();
        host(0, 1'b0, '0);
        #1;
        chk("t2_rvalid", 64'(bus.host_rvalid_o), 64'h1);
        chk("t2_err", 64'(bus.host_err_o), 64'h1);
        chk("t2_rdata", 64'(bus.host_rdata_o[0]), 64'h0);
        tick();

        // 3: slow device in flight blocks a RAM request from the other host
        host(0, 1'b1, SlowA);
        #1;
        chk("t3_gnt0", 64'(bus.host_gnt_o), 64'h1);
        chk("t3_dreq0", 64'(bus.device_req_o), 64'h4);
        tick();
        host(0, 1'b0, '0); host(1, 1'b1, RamA1);
        #1;
        chk("t3_block1", 64'(bus.host_gnt_o), 64'h0);
        chk("t3_block1_dreq", 64'(bus.device_req_o), 64'h0);
        tick();
        #1;
        chk("t3_block2", 64'(bus.host_gnt_o), 64'h0);
        tick();
        dev(2, 1'b1, 32'h0000_5555);
        #1;
        chk("t3_slow_rvalid", 64'(bus.host_rvalid_o), 64'h1);
        chk("t3_slow_rdata", 64'(bus.host_rdata_o[0]), 64'h5555);
        chk("t3_block3", 64'(bus.host_gnt_o), 64'h0);
        tick();
        dev(2, 1'b0, '0);
        #1;
        chk("t3_gnt1", 64'(bus.host_gnt_o), 64'h2);
        chk("t3_dreq1", 64'(bus.device_req_o), 64'h1);
        tick();
        host(1, 1'b0, '0);
        dev(0, 1'b1, 32'h0000_6666);
        #1;
        chk("t3_ram_rvalid", 64'(bus.host_rvalid_o), 64'h2);
        chk("t3_ram_rdata", 64'(bus.host_rdata_o[1]), 64'h6666);
        tick();
        dev(0, 1'b0, '0);

        // 4: tracker full blocks a third grant; a pop frees it only next cycle
        host(0, 1'b1, RamA0);
        #1;
        chk("t4_gnt1", 64'(bus.host_gnt_o), 64'h1);
        tick();
        #1;
        chk("t4_gnt2", 64'(bus.host_gnt_o), 64'h1);
        tick();
        #1;
        chk("t4_count_full", 64'(dut.count_q), 64'h2);
        chk("t4_gnt3_blocked", 64'(bus.host_gnt_o), 64'h0);
        chk("t4_dreq_blocked", 64'(bus.device_req_o), 64'h0);
        tick();
        dev(0, 1'b1, 32'h0000_0011);
        #1;
        chk("t4_pop_rvalid", 64'(bus.host_rvalid_o), 64'h1);
        chk("t4_pop_nogrant", 64'(bus.host_gnt_o), 64'h0);
        tick();
        dev(0, 1'b0, '0);
        #1;
        chk("t4_gnt_resume", 64'(bus.host_gnt_o), 64'h1);
        tick();
        host(0, 1'b0, '0);
        dev(0, 1'b1, 32'h0000_0022);
        #1;
        chk("t4_drain1", 64'(bus.host_rdata_o[0]), 64'h22);
        tick();
        dev(0, 1'b1, 32'h0000_0033);
        #1;
        chk("t4_drain2", 64'(bus.host_rdata_o[0]), 64'h33);
        tick();
        dev(0, 1'b0, '0);
        #1;
        chk("t4_count_empty", 64'(dut.count_q), 64'h0);

        // 5: spurious GPIO response with nothing outstanding
        dev(1, 1'b1, 32'hDEAD_BEEF);
        #1;
        chk("t5_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        chk("t5_flag", 64'(dut.spurious_rvalid), 64'h1);
        tick();
        chk("t5_count", 64'(dut.count_q), 64'h0);
        dev(1, 1'b0, '0);
        #1;

        // 6: reset with two in flight; late response afterwards is dropped
        host(0, 1'b1, RamA0);
        #1;
        chk("t6_gnt1", 64'(bus.host_gnt_o), 64'h1);
        tick();
        #1;
        chk("t6_gnt2", 64'(bus.host_gnt_o), 64'h1);
        tick();
        chk("t6_count2", 64'(dut.count_q), 64'h2);
        host(1, 1'b1, RamA1);
        dev(0, 1'b1, 32'h0000_7777);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 64'(dut.count_q), 64'h0);
        chk("t6_rst_rr", 64'(dut.rr_ptr_q), 64'h1);
        chk("t6_rst_gnt", 64'(bus.host_gnt_o), 64'h0);
        chk("t6_rst_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        chk("t6_rst_dreq", 64'(bus.device_req_o), 64'h0);
        tick();
        host(0, 1'b0, '0); host(1, 1'b0, '0);
        rst_n = 1'b1;
        #1;
        chk("t6_late_rvalid", 64'(bus.host_rvalid_o), 64'h0);
        tick();
        chk("t6_late_count", 64'(dut.count_q), 64'h0);
        dev(0, 1'b0, '0);
        host(0, 1'b1, RamA0); host(1, 1'b1, RamA1);
        #1;
        chk("t6_first_prio", 64'(bus.host_gnt_o), 64'h1);
        tick();
        host(0, 1'b0, '0); host(1, 1'b0, '0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
